// File: rtl/rom_dl_router_if.sv
// Download bus from hps_io plus the three ROM write ports and load status.
// The router is the slave. The download source and the ROM/status consumer form the master side.
interface rom_dl_router_if;
    logic        dl_download;
    logic        dl_wr;
    logic [7:0]  dl_index;
    logic [24:0] dl_addr;
    logic [7:0]  dl_data;
    logic        prog_we;
    logic [13:0] prog_addr;
    logic [7:0]  prog_data;
    logic        vec_we;
    logic [11:0] vec_addr;
    logic [7:0]  vec_data;
    logic        mbox_we;
    logic [9:0]  mbox_addr;
    logic [7:0]  mbox_data;
    logic        cpu_hold;
    logic        dl_done;
    logic        dl_overflow;
    logic [15:0] byte_count;
    logic [7:0]  checksum;

    modport slave (
        input  dl_download, dl_wr, dl_index, dl_addr, dl_data,
        output prog_we, prog_addr, prog_data, vec_we, vec_addr, vec_data,
               mbox_we, mbox_addr, mbox_data, cpu_hold, dl_done, dl_overflow,
               byte_count, checksum
    );

    modport master (
        output dl_download, dl_wr, dl_index, dl_addr, dl_data,
        input  prog_we, prog_addr, prog_data, vec_we, vec_addr, vec_data,
               mbox_we, mbox_addr, mbox_data, cpu_hold, dl_done, dl_overflow,
               byte_count, checksum
    );
endinterface

// File: rtl/rom_dl_router.sv
// Routes a byte-serial ROM image download into program, vector and mathbox ROMs.
// It holds the game CPU in reset until the load finishes, then waits a settling period.
module rom_dl_router #(
    parameter logic [7:0]  ROM_INDEX   = 8'h00,
    parameter int unsigned HOLD_CYCLES = 16
) (
    input  logic            clk_i,
    input  logic            reset,
    rom_dl_router_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

    logic        r_dl_download, r_dl_download_d, r_dl_wr, r_dl_wr_d;
    logic [7:0]  r_dl_index, r_dl_data;
    logic [24:0] r_dl_addr;
    state_t      r_state, w_next;
    logic [7:0]  r_hold_cnt;
    logic        r_prog_we, r_vec_we, r_mbox_we;
    logic [13:0] r_prog_addr;
    logic [11:0] r_vec_addr;
    logic [9:0]  r_mbox_addr;
    logic [7:0]  r_prog_data, r_vec_data, r_mbox_data;
    logic        r_cpu_hold, r_dl_done, r_dl_overflow;
    logic [15:0] r_byte_count;
    logic [7:0]  r_checksum;
    logic        w_idx_match, w_start, w_accept;
    logic        w_sel_prog, w_sel_vec, w_sel_mbox;

    // Input capture stage.
    // The edge history resets high, so a download or strobe that is already active when reset is released is not seen as a new rise.
    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            r_dl_download   <= 1'b1;
            r_dl_download_d <= 1'b1;
            r_dl_wr         <= 1'b1;
            r_dl_wr_d       <= 1'b1;
            r_dl_index      <= 8'h00;
            r_dl_addr       <= 25'h0;
            r_dl_data       <= 8'h00;
        end else begin
            r_dl_download   <= bus.dl_download;
            r_dl_download_d <= r_dl_download;
            r_dl_wr         <= bus.dl_wr;
            r_dl_wr_d       <= r_dl_wr;
            r_dl_index      <= bus.dl_index;
            r_dl_addr       <= bus.dl_addr;
            r_dl_data       <= bus.dl_data;
        end
    end

    assign w_idx_match = (r_dl_index == ROM_INDEX);
    assign w_start     = r_dl_download & ~r_dl_download_d & w_idx_match;
    assign w_accept    = (r_state == S_LOAD) & r_dl_download & w_idx_match & r_dl_wr & ~r_dl_wr_d;
    assign w_sel_prog  = (r_dl_addr < 25'h0003000);
    assign w_sel_vec   = (r_dl_addr >= 25'h0003000) && (r_dl_addr < 25'h0004000);
    assign w_sel_mbox  = (r_dl_addr >= 25'h0004000) && (r_dl_addr < 25'h0004400);

    // Next-state logic for the load sequencer.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start) w_next = S_LOAD;
                else         w_next = S_IDLE;
            end
            S_LOAD: begin
                if (!r_dl_download) w_next = S_FLUSH;
                else                w_next = S_LOAD;
            end
            S_FLUSH: begin
                if (w_start)                       w_next = S_LOAD;
                else if (r_hold_cnt == HOLD_LAST)  w_next = S_DONE;
                else                               w_next = S_FLUSH;
            end
            S_DONE: begin
                if (w_start) w_next = S_LOAD;
                else         w_next = S_DONE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State register and the counter for the post-load hold.
    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_hold_cnt <= 8'd0;
        end else begin
            r_state    <= w_next;
            r_hold_cnt <= ((r_state == S_FLUSH) && (w_next == S_FLUSH)) ? r_hold_cnt + 8'd1 : 8'd0;
        end
    end

    // Registered write ports, hold output and load status.
    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            r_prog_we     <= 1'b0;
            r_vec_we      <= 1'b0;
            r_mbox_we     <= 1'b0;
            r_prog_addr   <= 14'h0;
            r_vec_addr    <= 12'h0;
            r_mbox_addr   <= 10'h0;
            r_prog_data   <= 8'h00;
            r_vec_data    <= 8'h00;
            r_mbox_data   <= 8'h00;
            r_cpu_hold    <= 1'b0;
            r_dl_done     <= 1'b0;
            r_dl_overflow <= 1'b0;
            r_byte_count  <= 16'h0;
            r_checksum    <= 8'h00;
        end else begin
            r_prog_we  <= w_accept & w_sel_prog;
            r_vec_we   <= w_accept & w_sel_vec;
            r_mbox_we  <= w_accept & w_sel_mbox;
            r_cpu_hold <= (w_next == S_LOAD) || (w_next == S_FLUSH);
            if (w_accept && w_sel_prog) begin
                r_prog_addr <= r_dl_addr[13:0];
                r_prog_data <= r_dl_data;
            end
            // The vector and mathbox bases are aligned to their ROM sizes, so dropping the high bits subtracts the base.
            if (w_accept && w_sel_vec) begin
                r_vec_addr <= r_dl_addr[11:0];
                r_vec_data <= r_dl_data;
            end
            if (w_accept && w_sel_mbox) begin
                r_mbox_addr <= r_dl_addr[9:0];
                r_mbox_data <= r_dl_data;
            end
            if ((w_next == S_LOAD) && (r_state != S_LOAD)) begin
                r_byte_count  <= 16'h0;
                r_checksum    <= 8'h00;
                r_dl_overflow <= 1'b0;
                r_dl_done     <= 1'b0;
            end else if (w_accept) begin
                if (r_byte_count != 16'hFFFF) r_byte_count <= r_byte_count + 16'd1;
                r_checksum <= r_checksum + r_dl_data;
                if (r_dl_addr >= 25'h0004400) r_dl_overflow <= 1'b1;
            end else if ((r_state == S_FLUSH) && (w_next == S_DONE)) begin
                r_dl_done <= (r_byte_count != 16'h0);
            end
        end
    end

    assign bus.prog_we     = r_prog_we;
    assign bus.prog_addr   = r_prog_addr;
    assign bus.prog_data   = r_prog_data;
    assign bus.vec_we      = r_vec_we;
    assign bus.vec_addr    = r_vec_addr;
    assign bus.vec_data    = r_vec_data;
    assign bus.mbox_we     = r_mbox_we;
    assign bus.mbox_addr   = r_mbox_addr;
    assign bus.mbox_data   = r_mbox_data;
    assign bus.cpu_hold    = r_cpu_hold;
    assign bus.dl_done     = r_dl_done;
    assign bus.dl_overflow = r_dl_overflow;
    assign bus.byte_count  = r_byte_count;
    assign bus.checksum    = r_checksum;
endmodule

// File: doc/rom_dl_router.md
ROM_DL_ROUTER -- requirements
Module: rom_dl_router

Interface
REQ-001 Parameter ROM_INDEX, default 8'h00, download index accepted; other indices ignored.
REQ-002 Parameter HOLD_CYCLES, default 16, cycles cpu_hold stays high after download ends (range 1..255).
REQ-003 clk_i  in  1  system clock (50 MHz domain), all logic on rising edge; one clock, reset is asynchronous and active-high.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 dl_download  in  1  download-active level from hps_io.
REQ-006 dl_wr  in  1  byte-valid strobe, may be held >1 cycle.
REQ-007 dl_index  in  8  download index.
REQ-008 dl_addr  in  25  byte address within image.
REQ-009 dl_data  in  8  byte data.
REQ-010 prog_we / prog_addr / prog_data  out  1/14/8  program ROM write port (12 KiB).
REQ-011 vec_we / vec_addr / vec_data  out  1/12/8  vector ROM write port (4 KiB).
REQ-012 mbox_we / mbox_addr / mbox_data  out  1/10/8  mathbox PROM write port (1 KiB).
REQ-013 cpu_hold  out  1  active-high hold for game core reset.
REQ-014 dl_done  out  1  sticky: valid image loaded since reset.
REQ-015 dl_overflow  out  1  sticky: byte addressed beyond 0x43FF.
REQ-016 byte_count  out  16  accepted bytes, current/last download.
REQ-017 checksum  out  8  modulo-256 sum of accepted bytes.

Function
REQ-018 Inputs registered once; write accepted on rising edge of registered dl_wr while registered dl_download=1 and dl_index==ROM_INDEX; held strobe = one write.
REQ-019 Accepted byte produces exactly one *_we pulse, one cycle wide, two cycles after dl_wr rises at input; addr/data stable in that cycle.
REQ-020 Decode: 0x0000-0x2FFF -> prog (addr[13:0]); 0x3000-0x3FFF -> vec (addr-0x3000); 0x4000-0x43FF -> mbox (addr-0x4000).
REQ-021 Address >= 0x4400: no we pulse, dl_overflow set, byte still counted and summed.
REQ-022 At most one *_we high in any cycle; all we low outside LOAD.
REQ-023 FSM IDLE -> LOAD on dl_download rise with matching index; clears byte_count, checksum, dl_overflow, dl_done.
REQ-024 LOAD -> FLUSH on dl_download fall; a write already in the pipe still completes.
REQ-025 FLUSH counts HOLD_CYCLES then -> DONE; dl_done set on entry to DONE iff byte_count != 0.
REQ-026 DONE -> LOAD on next matching download rise; otherwise stays DONE.
REQ-027 cpu_hold = 1 in LOAD and FLUSH, 0 in IDLE and DONE.
REQ-028 Non-matching index download: state and outputs unchanged.
REQ-029 byte_count saturates at 0xFFFF; checksum wraps modulo 256.
REQ-030 dl_download rise during FLUSH restarts LOAD, counters cleared, hold counter abandoned.

Reset
REQ-031 reset asserted: state IDLE, all we 0, addr/data buses 0, cpu_hold 0, dl_done 0, dl_overflow 0, byte_count 0, checksum 0, hold counter 0.
REQ-032 reset mid-LOAD aborts immediately; no we pulse in or after the reset cycle until new download.
REQ-033 After reset deassert, first accepted write requires fresh dl_download rise.

Verification
REQ-034 Index 0, bytes 0x01 @0x0000, 0xFF @0x2FFF, 0x5A @0x3000, 0xA5 @0x43FF -> one prog_we each at 0x0000/0x2FFF, vec_we @0x000, mbox_we @0x3FF; byte_count=4, checksum=0xFF, dl_done=1 after 16 cycles.
REQ-035 dl_wr held 5 cycles, addr 0x0010 data 0x33 -> exactly one prog_we, byte_count=1.
REQ-036 Byte @0x4400 -> no we, dl_overflow=1, byte_count=1; next download clears dl_overflow.
REQ-037 Download with dl_index=1 -> no we, cpu_hold 0, all status unchanged.
REQ-038 reset pulsed after 3 of 6 bytes -> outputs per REQ-031, no further we; new download completes, byte_count=6.
REQ-039 dl_download re-rises 5 cycles into FLUSH -> cpu_hold stays 1, counters cleared, dl_done only after second FLUSH.
